activity_counter: RTL and testbench

// Synthesizable switching-activity monitor that sits directly downstream of
// the DUT under power analysis (e.g. the inputs/output of big_and).

---
 rtl/activity_pkg.sv | 36 +++
 rtl/activity_bit_counter.sv | 56 +++++
 rtl/activity_counter.sv | 135 +++++++++++++
 tb/tb_activity_counter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/activity_pkg.sv
// Shared types and helpers for the switching-activity monitor.
package activity_pkg;

    // Measurement FSM: idle, accumulating a window, streaming results.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        REPORT = 2'd2
    } state_e;

    // Counters are handled at this width inside sat_inc; CNT_W must not exceed it.
    localparam int SAT_W = 32;

    // Width of a bit index for a vector of `width` signals (at least 1 bit).
    function automatic int idx_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    // Saturating increment. Returns {sat, next}: sat is set when an increment
    // is requested while the counter already sits at max_val.
    function automatic logic [SAT_W:0] sat_inc(input logic [SAT_W-1:0] cnt,
                                               input logic [SAT_W-1:0] max_val,
                                               input logic             en);
        logic [SAT_W:0] res;
        res = {1'b0, cnt};
        if (en) begin
            if (cnt == max_val) begin
                res[SAT_W] = 1'b1;
            end else begin
                res = {1'b0, cnt + 1'b1};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/activity_bit_counter.sv
// Per-signal activity counters: toggle count, high-cycle count and a sticky
// saturation flag, plus the previous sample used for toggle detection.
module activity_bit_counter
    import activity_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic             i_sig,
    output logic [CNT_W-1:0] o_tog,
    output logic [CNT_W-1:0] o_high,
    output logic             o_sat
);

    localparam logic [SAT_W-1:0] CNT_MAX = SAT_W'({CNT_W{1'b1}});

    logic             r_prev;
    logic [CNT_W-1:0] r_tog;
    logic [CNT_W-1:0] r_high;
    logic             r_sat;

    logic [SAT_W:0]   w_tog_inc;
    logic [SAT_W:0]   w_high_inc;

    assign w_tog_inc  = sat_inc(SAT_W'(r_tog), CNT_MAX, i_sig ^ r_prev);
    assign w_high_inc = sat_inc(SAT_W'(r_high), CNT_MAX, i_sig);

    // Clear re-arms the window and captures the reference sample; enable
    // accumulates one counted cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= 1'b0;
            r_tog  <= '0;
            r_high <= '0;
            r_sat  <= 1'b0;
        end else if (i_clear) begin
            r_prev <= i_sig;
            r_tog  <= '0;
            r_high <= '0;
            r_sat  <= 1'b0;
        end else if (i_en) begin
            r_prev <= i_sig;
            r_tog  <= CNT_W'(w_tog_inc[SAT_W-1:0]);
            r_high <= CNT_W'(w_high_inc[SAT_W-1:0]);
            r_sat  <= r_sat | w_tog_inc[SAT_W] | w_high_inc[SAT_W];
        end
    end

    assign o_tog  = r_tog;
    assign o_high = r_high;
    assign o_sat  = r_sat;

endmodule

// File: rtl/activity_counter.sv
// Switching-activity monitor: counts per-bit toggles and high cycles over a
// start/stop window, then streams one result beat per bit over valid/ready.
module activity_counter
    import activity_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int CNT_W = 16,
    localparam int IDX_W = idx_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sig_i,
    input  logic             start_i,
    input  logic             stop_i,
    output logic             busy_o,
    output logic             rpt_valid_o,
    input  logic             rpt_ready_i,
    output logic [IDX_W-1:0] rpt_idx_o,
    output logic [CNT_W-1:0] rpt_tog_o,
    output logic [CNT_W-1:0] rpt_high_o,
    output logic [CNT_W-1:0] rpt_cycles_o,
    output logic             rpt_sat_o,
    output logic             done_o
);

    localparam logic [SAT_W-1:0] CNT_MAX  = SAT_W'({CNT_W{1'b1}});
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_e           r_state;
    logic             r_busy;
    logic             r_valid;
    logic             r_done;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_cycles;
    logic             r_cyc_sat;

    logic                        w_count;
    logic                        w_clear;
    logic                        w_handshake;
    logic [SAT_W:0]              w_cyc_inc;
    logic [WIDTH-1:0][CNT_W-1:0] w_tog;
    logic [WIDTH-1:0][CNT_W-1:0] w_high;
    logic [WIDTH-1:0]            w_sat;

    // A start from IDLE, or a start in COUNT without a simultaneous stop,
    // re-arms every counter; stop wins over start so that cycle is counted.
    assign w_count     = (r_state == COUNT);
    assign w_clear     = ((r_state == IDLE) && start_i) || (w_count && start_i && !stop_i);
    assign w_handshake = r_valid && rpt_ready_i;
    assign w_cyc_inc   = sat_inc(SAT_W'(r_cycles), CNT_MAX, 1'b1);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        activity_bit_counter #(
            .CNT_W (CNT_W)
        ) u_bit (
            .clk     (clk),
            .rst     (rst),
            .i_clear (w_clear),
            .i_en    (w_count),
            .i_sig   (sig_i[gi]),
            .o_tog   (w_tog[gi]),
            .o_high  (w_high[gi]),
            .o_sat   (w_sat[gi])
        );
    end

    // Window FSM, window-length counter and report beat sequencing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
            r_idx     <= '0;
            r_cycles  <= '0;
            r_cyc_sat <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_state   <= COUNT;
                        r_busy    <= 1'b1;
                        r_cycles  <= '0;
                        r_cyc_sat <= 1'b0;
                    end
                end
                COUNT: begin
                    if (stop_i) begin
                        r_cycles  <= CNT_W'(w_cyc_inc[SAT_W-1:0]);
                        r_cyc_sat <= r_cyc_sat | w_cyc_inc[SAT_W];
                        r_state   <= REPORT;
                        r_valid   <= 1'b1;
                        r_idx     <= '0;
                    end else if (start_i) begin
                        r_cycles  <= '0;
                        r_cyc_sat <= 1'b0;
                    end else begin
                        r_cycles  <= CNT_W'(w_cyc_inc[SAT_W-1:0]);
                        r_cyc_sat <= r_cyc_sat | w_cyc_inc[SAT_W];
                    end
                end
                REPORT: begin
                    if (w_handshake) begin
                        if (r_idx == LAST_IDX) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_valid <= 1'b0;
                            r_idx   <= '0;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    // Counters are frozen during REPORT, so the beat mux only selects flops.
    assign busy_o       = r_busy;
    assign rpt_valid_o  = r_valid;
    assign rpt_idx_o    = r_idx;
    assign rpt_tog_o    = w_tog[r_idx];
    assign rpt_high_o   = w_high[r_idx];
    assign rpt_cycles_o = r_cycles;
    assign rpt_sat_o    = r_cyc_sat | (|w_sat);
    assign done_o       = r_done;

endmodule

// File: tb/tb_activity_counter.sv
// Bench for activity_counter: two instances (CNT_W=16 and CNT_W=4) share the
// same stimulus; expectations come from a recorded sample history per window.
module tb_activity_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  sig = 4'h0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        ready = 1'b0;

    logic        a_busy, a_valid, a_sat, a_done;
    logic [1:0]  a_idx;
    logic [15:0] a_tog, a_high, a_cyc;
    logic        b_busy, b_valid, b_sat, b_done;
    logic [1:0]  b_idx;
    logic [3:0]  b_tog, b_high, b_cyc;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: phase 0 idle, 1 counting, 2 reporting.
    logic [3:0] hist[$];
    int         m_phase = 0;
    int         m_idx   = 0;
    bit         m_done  = 1'b0;

    always #5 clk = ~clk;

    activity_counter #(.WIDTH(4), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .sig_i(sig), .start_i(start), .stop_i(stop),
        .busy_o(a_busy), .rpt_valid_o(a_valid), .rpt_ready_i(ready),
        .rpt_idx_o(a_idx), .rpt_tog_o(a_tog), .rpt_high_o(a_high),
        .rpt_cycles_o(a_cyc), .rpt_sat_o(a_sat), .done_o(a_done)
    );

    activity_counter #(.WIDTH(4), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .sig_i(sig), .start_i(start), .stop_i(stop),
        .busy_o(b_busy), .rpt_valid_o(b_valid), .rpt_ready_i(ready),
        .rpt_idx_o(b_idx), .rpt_tog_o(b_tog), .rpt_high_o(b_high),
        .rpt_cycles_o(b_cyc), .rpt_sat_o(b_sat), .done_o(b_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Window statistics straight from the sample history (hist[0] is the
    // reference sample taken on the start cycle).
    function automatic int cnt_tog(input int b);
        int t = 0;
        for (int k = 1; k < hist.size(); k++) if (hist[k][b] != hist[k-1][b]) t++;
        return t;
    endfunction

    function automatic int cnt_high(input int b);
        int h = 0;
        for (int k = 1; k < hist.size(); k++) if (hist[k][b]) h++;
        return h;
    endfunction

    function automatic int cnt_cyc();
        return hist.size() - 1;
    endfunction

    function automatic int clip(input int v, input int w);
        int m = (1 << w) - 1;
        return (v > m) ? m : v;
    endfunction

    function automatic bit exp_sat(input int w);
        int m = (1 << w) - 1;
        bit s = (cnt_cyc() > m);
        for (int b = 0; b < 4; b++) s = s | (cnt_tog(b) > m) | (cnt_high(b) > m);
        return s;
    endfunction

    task automatic check_outputs();
        chk("busy_a",  a_busy,  64'(m_phase != 0));
        chk("busy_b",  b_busy,  64'(m_phase != 0));
        chk("valid_a", a_valid, 64'(m_phase == 2));
        chk("valid_b", b_valid, 64'(m_phase == 2));
        chk("done_a",  a_done,  64'(m_done));
        chk("done_b",  b_done,  64'(m_done));
        if (m_phase == 2) begin
            chk("idx_a",  a_idx,  64'(m_idx));
            chk("idx_b",  b_idx,  64'(m_idx));
            chk("tog_a",  a_tog,  64'(clip(cnt_tog(m_idx), 16)));
            chk("high_a", a_high, 64'(clip(cnt_high(m_idx), 16)));
            chk("cyc_a",  a_cyc,  64'(clip(cnt_cyc(), 16)));
            chk("sat_a",  a_sat,  64'(exp_sat(16)));
            chk("tog_b",  b_tog,  64'(clip(cnt_tog(m_idx), 4)));
            chk("high_b", b_high, 64'(clip(cnt_high(m_idx), 4)));
            chk("cyc_b",  b_cyc,  64'(clip(cnt_cyc(), 4)));
            chk("sat_b",  b_sat,  64'(exp_sat(4)));
        end
    endtask

    // Advance the model with the inputs present before the edge, clock once,
    // then compare both instances against the model.
    task automatic tick();
        m_done = 1'b0;
        case (m_phase)
            0: if (start) begin
                hist.delete();
                hist.push_back(sig);
                m_phase = 1;
            end
            1: if (stop) begin
                hist.push_back(sig);
                m_phase = 2;
                m_idx   = 0;
            end else if (start) begin
                hist.delete();
                hist.push_back(sig);
            end else begin
                hist.push_back(sig);
            end
            default: if (ready) begin
                if (m_idx == 3) begin
                    m_phase = 0;
                    m_done  = 1'b1;
                end else begin
                    m_idx++;
                end
            end
        endcase
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic drain_to_idle();
        int guard = 0;
        while (m_phase == 2 && guard < 200) begin
            tick();
            guard++;
        end
        if (m_phase == 2) begin
            n_checks++;
            n_fail++;
            $error("FAIL drain_timeout: observed valid after %0d cycles required idle", guard);
        end
    endtask

    initial begin
        int ndone;
        int len;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",  a_busy,  0);
        chk("rst_valid", a_valid, 0);
        chk("rst_done",  a_done,  0);
        chk("rst_idx",   a_idx,   0);
        chk("rst_tog",   a_tog,   0);
        chk("rst_cyc",   a_cyc,   0);
        chk("rst_sat",   a_sat,   0);
        chk("rst_valid_b", b_valid, 0);
        rst = 1'b0;

        // Stop in IDLE is ignored
        stop = 1'b1; tick(); stop = 1'b0;

        // Ramp pattern: 0000 start, 0001,0011,0111,1111, then 1111 x10 with stop
        sig = 4'h0; start = 1'b1; tick(); start = 1'b0;
        sig = 4'h1; tick();
        sig = 4'h3; tick();
        sig = 4'h7; tick();
        sig = 4'hF; tick();
        for (int k = 0; k < 10; k++) begin
            stop = (k == 9);
            tick();
        end
        stop = 1'b0;
        ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("ramp_cycles", a_cyc, 14);
            chk("ramp_tog", a_tog, 1);
            chk("ramp_high", a_high, 64'(14 - k));
            chk("ramp_sat", a_sat, 0);
            tick();
        end

        // Saturation: bit0 toggles every cycle for 20 cycles; beat 1 backpressured
        sig = 4'h0; start = 1'b1; tick(); start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            sig  = 4'(k % 2);
            stop = (k == 20);
            tick();
        end
        stop = 1'b0;
        chk("sat16_tog", a_tog, 20);
        chk("sat16_high", a_high, 10);
        chk("sat16_cyc", a_cyc, 20);
        chk("sat16_flag", a_sat, 0);
        chk("sat4_tog", b_tog, 15);
        chk("sat4_high", b_high, 10);
        chk("sat4_cyc", b_cyc, 15);
        chk("sat4_flag", b_sat, 1);
        ready = 1'b1; tick();
        ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_idx", a_idx, 1);
            chk("bp_valid", a_valid, 1);
        end
        ready = 1'b1;
        ndone = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            ndone += int'(a_done);
        end
        chk("done_pulses", 64'(ndone), 1);

        // Restart: 5 toggling cycles, restart, 2 steady cycles, stop
        sig = 4'h0; start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            sig = (k % 2 == 0) ? 4'hA : 4'h5;
            tick();
        end
        sig = 4'h5; start = 1'b1; tick(); start = 1'b0;
        tick();
        stop = 1'b1; tick(); stop = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("restart_cycles", a_cyc, 2);
            chk("restart_tog", a_tog, 0);
            tick();
        end

        // start and stop together in COUNT: stop wins, cycle counted
        sig = 4'h3; start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sig = 4'($urandom);
            tick();
        end
        sig = 4'($urandom); start = 1'b1; stop = 1'b1; tick();
        start = 1'b0; stop = 1'b0;
        chk("ss_valid", a_valid, 1);
        chk("ss_cycles", a_cyc, 4);
        drain_to_idle();

        // Reset while beat 2 is pending
        sig = 4'h0; start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sig = 4'($urandom);
            stop = (k == 3);
            tick();
        end
        stop = 1'b0;
        tick(); tick();
        ready = 1'b0;
        tick();
        chk("pre_rst_idx", a_idx, 2);
        rst = 1'b1;
        #1;
        chk("rst_mid_valid_a", a_valid, 0);
        chk("rst_mid_valid_b", b_valid, 0);
        chk("rst_mid_busy_a",  a_busy,  0);
        chk("rst_mid_busy_b",  b_busy,  0);
        m_phase = 0;
        m_idx   = 0;
        m_done  = 1'b0;
        hist.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        stop = 1'b1; ready = 1'b1; tick(); stop = 1'b0;
        chk("post_rst_stop_busy", a_busy, 0);
        chk("post_rst_stop_valid", a_valid, 0);

        // Randomized windows with restarts, backpressure and ignored controls
        for (int w = 0; w < 10; w++) begin
            sig = 4'($urandom); start = 1'b1; stop = 1'b0; tick();
            start = 1'b0;
            len = $urandom_range(1, 30);
            for (int c = 0; c < len; c++) begin
                sig   = 4'($urandom);
                start = ($urandom_range(0, 9) == 0);
                stop  = (c == len - 1);
                if (stop) start = 1'($urandom_range(0, 1));
                tick();
            end
            begin
                int guard = 0;
                while (m_phase == 2 && guard < 200) begin
                    sig   = 4'($urandom);
                    ready = 1'($urandom_range(0, 1));
                    start = 1'($urandom_range(0, 1));
                    stop  = 1'($urandom_range(0, 1));
                    tick();
                    guard++;
                end
                if (m_phase == 2) begin
                    n_checks++;
                    n_fail++;
                    $error("FAIL rand_drain_timeout: observed valid after %0d cycles required idle", guard);
                end
            end
            start = 1'b0;
            ready = 1'b1;
            sig = 4'($urandom); stop = 1'b1; tick();
            stop = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
